// File: rtl/multicycle_control.sv
// Multicycle controller: sequences FETCH/DECODE/EXEC/MEM/WB/HALTED and
// decodes the datapath controls from the current state and the latched
// instruction fields. A memory wait counter forces HALTED with a sticky
// fault flag when memReady stays low for too long.
module multicycle_control #(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter int unsigned CNTW       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opCode,
    input  logic [3:0] functionCode,
    input  logic       memReady,
    input  logic       branchTaken,
    output logic       irWrite,
    output logic       pcWrite,
    output logic       regWrite,
    output logic       r0Write,
    output logic       ra1Source,
    output logic       ra2Source,
    output logic       halt,
    output logic       aluSource,
    output logic       memRead,
    output logic       memWrite,
    output logic       memSource,
    output logic       fnOffset,
    output logic [1:0] pcSource,
    output logic [2:0] state,
    output logic       illegal,
    output logic       fault
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalted = 3'd5
    } state_t;

    localparam logic [3:0] OpRtype = 4'b0000;
    localparam logic [3:0] OpLoad  = 4'b1000;
    localparam logic [3:0] OpStore = 4'b1011;
    localparam logic [3:0] OpBeq   = 4'b0100;
    localparam logic [3:0] OpBne   = 4'b0101;
    localparam logic [3:0] OpBlt   = 4'b0110;
    localparam logic [3:0] OpJump  = 4'b1100;
    localparam logic [3:0] OpHalt  = 4'b1111;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_op;
    logic [3:0]        r_fn;
    logic [CNTW-1:0]   r_cnt;
    logic              r_fault;
    logic              w_waiting;
    logic              w_timeout;

    // A wait cycle is a FETCH/MEM cycle without memReady; the last allowed
    // one (counter about to reach WAIT_LIMIT) times out instead of waiting.
    assign w_waiting = ((r_state == StFetch) || (r_state == StMem)) && !memReady;
    assign w_timeout = w_waiting && (r_cnt == CNTW'(WAIT_LIMIT - 1));

    assign state = r_state;
    assign fault = r_fault;

    // Next-state and control decode; everything defaults to inactive.
    always_comb begin
        w_next    = r_state;
        irWrite   = 1'b0;
        pcWrite   = 1'b0;
        regWrite  = 1'b0;
        r0Write   = 1'b0;
        ra1Source = 1'b0;
        ra2Source = 1'b0;
        halt      = 1'b0;
        aluSource = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        memSource = 1'b0;
        fnOffset  = 1'b0;
        pcSource  = 2'b00;
        illegal   = 1'b0;
        case (r_state)
            StFetch: begin
                memRead = 1'b1;
                if (memReady) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    w_next  = StDecode;
                end else if (w_timeout) begin
                    w_next = StHalted;
                end
            end
            StDecode: begin
                case (r_op)
                    OpRtype, OpLoad, OpStore, OpBeq, OpBne, OpBlt, OpJump: w_next = StExec;
                    OpHalt:  w_next = StHalted;
                    default: begin
                        illegal = 1'b1;
                        w_next  = StFetch;
                    end
                endcase
            end
            StExec: begin
                case (r_op)
                    OpRtype: w_next = StWb;
                    OpLoad, OpStore: begin
                        aluSource = 1'b1;
                        fnOffset  = 1'b1;
                        ra2Source = (r_op == OpStore);
                        w_next    = StMem;
                    end
                    OpBeq, OpBne, OpBlt: begin
                        ra1Source = 1'b1;
                        ra2Source = 1'b1;
                        fnOffset  = 1'b1;
                        pcSource  = 2'b10;
                        pcWrite   = branchTaken;
                        w_next    = StFetch;
                    end
                    OpJump: begin
                        ra1Source = 1'b1;
                        ra2Source = 1'b1;
                        fnOffset  = 1'b1;
                        pcSource  = 2'b01;
                        pcWrite   = 1'b1;
                        w_next    = StFetch;
                    end
                    default: w_next = StFetch;
                endcase
            end
            StMem: begin
                if (r_op == OpStore) begin
                    memWrite = 1'b1;
                end else begin
                    memRead   = 1'b1;
                    memSource = 1'b1;
                end
                if (memReady) begin
                    w_next = (r_op == OpStore) ? StFetch : StWb;
                end else if (w_timeout) begin
                    w_next = StHalted;
                end
            end
            StWb: begin
                regWrite = 1'b1;
                r0Write  = (r_op == OpRtype) && ((r_fn == 4'b0001) || (r_fn == 4'b0010));
                w_next   = StFetch;
            end
            StHalted: begin
                halt      = 1'b1;
                ra1Source = 1'b1;
                ra2Source = 1'b1;
                fnOffset  = 1'b1;
            end
            default: w_next = StFetch;
        endcase
    end

    // State, latched instruction fields, wait counter and sticky fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StFetch;
            r_op    <= 4'b0000;
            r_fn    <= 4'b0000;
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == StFetch) && memReady) begin
                r_op <= opCode;
                r_fn <= functionCode;
            end
            // Any cycle that is not a continued wait leaves the counter at 0,
            // so it is already clear when FETCH/MEM is entered.
            if (w_waiting && !w_timeout) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            if (w_timeout) begin
                r_fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: the driver pushes hand-computed per-cycle output vectors
// into a queue; a monitor on the falling edge pops and compares them.
module tb_multicycle_control;

    logic       clk;
    logic       rst;
    logic [3:0] opCode;
    logic [3:0] functionCode;
    logic       memReady;
    logic       branchTaken;
    logic       irWrite, pcWrite, regWrite, r0Write, ra1Source, ra2Source, halt;
    logic       aluSource, memRead, memWrite, memSource, fnOffset, illegal, fault;
    logic [1:0] pcSource;
    logic [2:0] state;

    multicycle_control #(.WAIT_LIMIT(15), .CNTW(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .opCode       (opCode),
        .functionCode (functionCode),
        .memReady     (memReady),
        .branchTaken  (branchTaken),
        .irWrite      (irWrite),
        .pcWrite      (pcWrite),
        .regWrite     (regWrite),
        .r0Write      (r0Write),
        .ra1Source    (ra1Source),
        .ra2Source    (ra2Source),
        .halt         (halt),
        .aluSource    (aluSource),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .memSource    (memSource),
        .fnOffset     (fnOffset),
        .pcSource     (pcSource),
        .state        (state),
        .illegal      (illegal),
        .fault        (fault)
    );

    // Vector layout: state, illegal, fault, irWrite, pcWrite, pcSource,
    // regWrite, r0Write, ra1, ra2, halt, aluSource, memRead, memWrite,
    // memSource, fnOffset.
    localparam logic [18:0] S0   = 19'h00000;
    localparam logic [18:0] S1   = 19'h10000;
    localparam logic [18:0] S2   = 19'h20000;
    localparam logic [18:0] S3   = 19'h30000;
    localparam logic [18:0] S4   = 19'h40000;
    localparam logic [18:0] S5   = 19'h50000;
    localparam logic [18:0] ILL  = 19'h08000;
    localparam logic [18:0] FLT  = 19'h04000;
    localparam logic [18:0] IRW  = 19'h02000;
    localparam logic [18:0] PCW  = 19'h01000;
    localparam logic [18:0] PCB  = 19'h00800;
    localparam logic [18:0] PCJ  = 19'h00400;
    localparam logic [18:0] RW   = 19'h00200;
    localparam logic [18:0] R0W  = 19'h00100;
    localparam logic [18:0] RA1  = 19'h00080;
    localparam logic [18:0] RA2  = 19'h00040;
    localparam logic [18:0] HLT  = 19'h00020;
    localparam logic [18:0] ALUS = 19'h00010;
    localparam logic [18:0] MR   = 19'h00008;
    localparam logic [18:0] MW   = 19'h00004;
    localparam logic [18:0] MS   = 19'h00002;
    localparam logic [18:0] FO   = 19'h00001;
    localparam logic [18:0] HALTED_V = S5 | HLT | RA1 | RA2 | FO;

    logic [18:0] w_got;
    assign w_got = {state, illegal, fault, irWrite, pcWrite, pcSource, regWrite, r0Write,
                    ra1Source, ra2Source, halt, aluSource, memRead, memWrite, memSource,
                    fnOffset};

    logic [18:0] q_v[$];
    string       q_n[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [18:0] m_e;
    string       m_nm;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: one expected vector per checked cycle.
    always @(negedge clk) begin
        if (q_v.size() > 0) begin
            m_e  = q_v.pop_front();
            m_nm = q_n.pop_front();
            n_checks++;
            if (w_got !== m_e) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", m_nm, w_got, m_e);
            end
        end
    end

    task automatic cyc(input logic r, input logic [3:0] op, input logic [3:0] fn,
                       input logic mr, input logic bt, input logic chk,
                       input logic [18:0] e, input string nm);
        @(posedge clk);
        #1;
        rst          = r;
        opCode       = op;
        functionCode = fn;
        memReady     = mr;
        branchTaken  = bt;
        if (chk) begin
            q_v.push_back(e);
            q_n.push_back(nm);
        end
    endtask

    // Checked cycle with a junk opcode on the bus (must not be latched).
    task automatic c(input logic mr, input logic bt, input logic [18:0] e, input string nm);
        cyc(1'b0, 4'hF, 4'hF, mr, bt, 1'b1, e, nm);
    endtask

    // FETCH cycle that completes with the given instruction.
    task automatic f(input logic [3:0] op, input logic [3:0] fn, input string nm);
        cyc(1'b0, op, fn, 1'b1, 1'b0, 1'b1, S0 | MR | IRW | PCW, nm);
    endtask

    task automatic do_rst(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, S0, "rst");
    endtask

    initial begin
        rst = 1'b1; opCode = 4'h0; functionCode = 4'h0; memReady = 1'b0; branchTaken = 1'b0;
        do_rst(2);
        c(0, 0, S0 | MR, "reset_fetch");

        // R-type writing r0 (fn 0001), then fn 0010, then fn 0011
        f(4'h0, 4'h1, "rt1_fetch");
        c(0, 0, S1, "rt1_dec");
        c(0, 0, S2, "rt1_exec");
        c(0, 0, S4 | RW | R0W, "rt1_wb");
        f(4'h0, 4'h2, "rt2_fetch");
        c(0, 0, S1, "rt2_dec");
        c(0, 0, S2, "rt2_exec");
        c(0, 0, S4 | RW | R0W, "rt2_wb");
        f(4'h0, 4'h3, "rt3_fetch");
        c(0, 0, S1, "rt3_dec");
        c(0, 0, S2, "rt3_exec");
        c(0, 0, S4 | RW, "rt3_wb");

        // 14 wait cycles, memReady on the 15th completes without fault
        for (int i = 0; i < 14; i++) c(0, 0, S0 | MR, "edge_wait");
        f(4'h0, 4'h1, "edge_fetch_ok");
        c(0, 0, S1, "edge_dec");
        c(0, 0, S2, "edge_exec");
        c(0, 0, S4 | RW | R0W, "edge_wb");

        // Load with three MEM wait cycles
        f(4'h8, 4'h0, "ld_fetch");
        c(0, 0, S1, "ld_dec");
        c(0, 0, S2 | ALUS | FO, "ld_exec");
        for (int i = 0; i < 3; i++) c(0, 0, S3 | MR | MS, "ld_mem_wait");
        c(1, 0, S3 | MR | MS, "ld_mem_done");
        c(0, 0, S4 | RW, "ld_wb");

        // Store, zero-wait
        f(4'hB, 4'h0, "st_fetch");
        c(0, 0, S1, "st_dec");
        c(0, 0, S2 | ALUS | FO | RA2, "st_exec");
        c(1, 0, S3 | MW, "st_mem");

        // Branches not taken / taken, then jump
        f(4'h6, 4'h0, "br6_fetch");
        c(0, 0, S1, "br6_dec");
        c(0, 0, S2 | RA1 | RA2 | FO | PCB, "br6_nt_exec");
        f(4'h6, 4'h0, "br6b_fetch");
        c(0, 0, S1, "br6b_dec");
        c(0, 1, S2 | RA1 | RA2 | FO | PCB | PCW, "br6_t_exec");
        f(4'h4, 4'h0, "br4_fetch");
        c(0, 0, S1, "br4_dec");
        c(0, 1, S2 | RA1 | RA2 | FO | PCB | PCW, "br4_t_exec");
        f(4'h5, 4'h0, "br5_fetch");
        c(0, 0, S1, "br5_dec");
        c(0, 0, S2 | RA1 | RA2 | FO | PCB, "br5_nt_exec");
        f(4'hC, 4'h0, "jmp_fetch");
        c(0, 0, S1, "jmp_dec");
        c(0, 0, S2 | RA1 | RA2 | FO | PCJ | PCW, "jmp_exec");

        // FETCH timeout: 15 wait cycles, then HALTED with fault
        for (int i = 0; i < 15; i++) c(0, 0, S0 | MR, "to_wait");
        for (int i = 0; i < 3; i++) c(1, 0, HALTED_V | FLT, "to_halted");
        do_rst(1);
        c(0, 0, S0 | MR, "fault_clr");

        // Illegal opcodes
        f(4'h3, 4'h0, "ill3_fetch");
        c(0, 0, S1 | ILL, "ill3_dec");
        c(0, 0, S0 | MR, "ill3_back");
        f(4'h7, 4'h1, "ill7_fetch");
        c(0, 0, S1 | ILL, "ill7_dec");
        c(0, 0, S0 | MR, "ill7_back");

        // HALT held 20 cycles regardless of memReady, reset releases it
        f(4'hF, 4'h0, "hlt_fetch");
        c(0, 0, S1, "hlt_dec");
        for (int i = 0; i < 20; i++) c(i[0], 0, HALTED_V, "hlt_hold");
        do_rst(1);
        c(0, 0, S0 | MR, "hlt_rst");

        // Reset in the middle of a stalled store
        f(4'hB, 4'h0, "st2_fetch");
        c(0, 0, S1, "st2_dec");
        c(0, 0, S2 | ALUS | FO | RA2, "st2_exec");
        c(0, 0, S3 | MW, "st2_mem_wait");
        c(0, 0, S3 | MW, "st2_mem_wait");
        do_rst(1);
        c(0, 0, S0 | MR, "mem_rst");

        for (int k = 0; k < 10 && q_v.size() > 0; k++) @(negedge clk);
        #1;
        n_checks++;
        if (q_v.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q_v.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
